bus_initiator: RTL
==================

// Module: bus_initiator
// PURPOSE
//  Bus master (initiator) end of the CS_/As_/RW/Rdy_ peripheral bus; the peripherals are the responders.
//  Takes single read/write requests from a local requester (core, DMA), drives As_/RW/Addr/WrData.
//  Waits for the responder's active-low Rdy_, returns read data plus a completion pulse.
//  CS_ is produced by the external address decoder from Addr/As_, not by this block.
//  A watchdog aborts accesses to absent or hung slaves.
// PARAMETERS
//  ADDR_W   30  word-address width (Addr, req_addr)
//  DATA_W   32  data width (WrData, RdData, req_wdata, rsp_rdata)
//  TIMEOUT  16  max ACCESS cycles waiting for Rdy_; 0 = wait forever
//  TO_W     5   watchdog counter width, must hold TIMEOUT
// PORTS
//  clk        in   1       single clock, all logic on posedge
//  reset      in   1       asynchronous, active-high reset
//  req_valid  in   1       request present
//  req_ready  out  1       request accepted this cycle when req_valid & req_ready
//  req_rw     in   1       1 = read, 0 = write (bus READ/WRITE encoding)
//  req_addr   in   ADDR_W  word address
//  req_wdata  in   DATA_W  write data
//  rsp_valid  out  1       one-cycle completion pulse
//  rsp_rdata  out  DATA_W  read data; 0 for writes and errors
//  rsp_err    out  1       1 = access timed out, qualified by rsp_valid
//  As_        out  1       address strobe, active low
//  RW         out  1       1 = read, 0 = write
//  Addr       out  ADDR_W  bus word address
//  WrData     out  DATA_W  bus write data
//  RdData     in   DATA_W  responder read data, valid when Rdy_ = 0
//  Rdy_       in   1       responder ready, active low
// BEHAVIOUR
//  Outputs: all registered.
//  Reset values: As_=1, RW=1, Addr=0, WrData=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, state=IDLE, watchdog=0.
//  Reset behaviour: reset forces these values immediately, even mid-access; no response is issued for the aborted access.
//  FSM states: IDLE, ACCESS, RESP.
//  req_ready: combinational, = (state==IDLE) | (state==RESP).
//  Accept (req_valid & req_ready at an edge):
//   - latch req_rw/req_addr/req_wdata into RW/Addr/WrData;
//   - As_<=0; watchdog<=0; next state ACCESS.
//  ACCESS:
//   - As_, RW, Addr, WrData are held constant.
//   - Rdy_ is sampled on each edge.
//  Rdy_==0 sampled in ACCESS:
//   - rsp_rdata <= RW ? RdData : 0; rsp_err<=0; rsp_valid<=1; As_<=1; next state RESP.
//  Watchdog:
//   - increments each ACCESS edge with Rdy_==1.
//   - If TIMEOUT!=0 and the count reaches TIMEOUT-1 with Rdy_ still 1: rsp_err<=1, rsp_rdata<=0, rsp_valid<=1, As_<=1, RESP.
//   - Rdy_==0 on that same edge wins: normal completion, no error.
//  RESP: lasts exactly one cycle.
//   - rsp_valid=1 in this cycle only; cleared on the next edge.
//   - A new request may be accepted in RESP: the slave has sampled As_=1 by then, so the stale Rdy_ has cleared before it is next sampled.
//   - If no new request: next state IDLE; RW/Addr/WrData keep their last values.
//  Rdy_ in IDLE or RESP: ignored, including a stale Rdy_=0 right after reset or completion.
//  Latency: zero-wait slave (Rdy_ one cycle after As_): accept edge E, capture at E+2, rsp_valid high E+2..E+3.
//   - Each extra wait state adds 1 cycle.
//  Throughput: with a continuous request stream and zero-wait slaves, one access per 3 cycles.
//   - As_ pattern: 0,0,1 repeating.
//  rsp_rdata/rsp_err hold their values until the next completion.
// TESTING
//  Responder model: registered Rdy_=0 one cycle after As_=0; optional extra wait states N.
//  1 Reset: assert reset mid-idle -> As_=1, RW=1, Addr=0, rsp_valid=0, req_ready=1.
//  2 Write: addr 0x1, data 0xA5, N=0 -> As_ low 2 cycles, RW=0, WrData=0xA5; rsp_valid 1 cycle at E+2, rsp_err=0, rsp_rdata=0.
//  3 Read: addr 0x0, model RdData=0x00001234, N=3 -> As_ low 5 cycles; rsp_rdata=0x00001234 at E+5.
//  4 Back-to-back: 4 reads with req_valid held high -> As_ = 0,0,1 repeated, 4 rsp_valid pulses, addresses in order.
//  5 Timeout: TIMEOUT=16, Rdy_ stuck 1 -> As_ low 16 cycles, then rsp_valid=1, rsp_err=1, rsp_rdata=0.
//    Next access to a good slave completes with rsp_err=0.
//  6 Reset mid-access: assert reset one cycle after accept -> As_=1 asynchronously, no rsp_valid.
//    Stray Rdy_=0 in the following cycle is ignored; the next request completes normally.

Source files
------------

// File: rtl/bus_initiator.sv
// -----------------------------------------------------------------------------
// bus_initiator
//
// Initiator (bus master) end of the CS_/As_/RW/Rdy_ peripheral bus. The block
// accepts one read or write at a time from a local requester. It drives the
// address strobe and the address/data lines, then waits for the responder to
// pull Rdy_ low. It returns the read data to the requester with a one-cycle
// completion pulse. CS_ is produced outside this block by the address decoder.
//
// A watchdog limits how long an access may wait for Rdy_. When the limit is
// reached the access ends with rsp_err set, so an absent or hung responder
// cannot lock up the bus.
//
// Parameters
//   ADDR_W   word-address width of req_addr / Addr
//   DATA_W   data width of all data ports
//   TIMEOUT  maximum ACCESS cycles spent waiting for Rdy_ (0 = no limit)
//   TO_W     watchdog counter width; must be able to hold TIMEOUT
//
// Ports
//   clk        in   single clock, all logic on its rising edge
//   reset      in   asynchronous, active-high reset
//   req_valid  in   request present
//   req_ready  out  request accepted on an edge where req_valid & req_ready
//   req_rw     in   1 = read, 0 = write
//   req_addr   in   word address of the request
//   req_wdata  in   write data of the request
//   rsp_valid  out  one-cycle completion pulse
//   rsp_rdata  out  read data (0 for writes and timed-out accesses)
//   rsp_err    out  1 = access timed out; qualified by rsp_valid
//   As_        out  address strobe, active low
//   RW         out  bus direction, 1 = read, 0 = write
//   Addr       out  bus word address
//   WrData     out  bus write data
//   RdData     in   responder read data, valid while Rdy_ = 0
//   Rdy_       in   responder ready, active low
// -----------------------------------------------------------------------------
module bus_initiator #(
  parameter int ADDR_W  = 30,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5
) (
  input  logic              clk,
  input  logic              reset,
  // requester side
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  // bus side
  output logic              As_,
  output logic              RW,
  output logic [ADDR_W-1:0] Addr,
  output logic [DATA_W-1:0] WrData,
  input  logic [DATA_W-1:0] RdData,
  input  logic              Rdy_
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  // The watchdog fires when the count already equals TIMEOUT-1 and Rdy_ is
  // still high. Together with the cycle of the accept edge, this gives exactly
  // TIMEOUT cycles of As_ low.
  localparam bit              WD_EN   = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] WD_LAST = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

  state_e              state_q,     state_d;
  logic                as_n_q,      as_n_d;
  logic                rw_q,        rw_d;
  logic [ADDR_W-1:0]   addr_q,      addr_d;
  logic [DATA_W-1:0]   wdata_q,     wdata_d;
  logic [TO_W-1:0]     wd_q,        wd_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q,   rsp_err_d;

  // A new request can be taken in RESP as well as in IDLE. By the time the next
  // ACCESS samples Rdy_, the responder has seen As_ high for one edge, so its
  // previous Rdy_ = 0 has already gone away.
  assign req_ready = (state_q == S_IDLE) || (state_q == S_RESP);

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case statement, so no path
    // can leave one unassigned and infer a latch.
    state_d     = state_q;
    as_n_d      = as_n_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wd_d        = wd_q;
    rsp_valid_d = 1'b0;          // completion is a single-cycle pulse
    rsp_rdata_d = rsp_rdata_q;   // response data holds until the next completion
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      // Rdy_ is deliberately ignored here. A stale low after reset or after a
      // completion must not be mistaken for a handshake.
      S_IDLE, S_RESP: begin
        if (req_valid) begin
          rw_d    = req_rw;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          as_n_d  = 1'b0;
          wd_d    = '0;
          state_d = S_ACCESS;
        end else begin
          // RW/Addr/WrData keep their last values when the bus goes idle.
          state_d = S_IDLE;
        end
      end

      S_ACCESS: begin
        if (!Rdy_) begin
          // A ready on the same edge the watchdog would fire still counts as a
          // normal completion.
          rsp_rdata_d = rw_q ? RdData : '0;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          as_n_d      = 1'b1;
          state_d     = S_RESP;
        end else if (WD_EN && (wd_q == WD_LAST)) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          as_n_d      = 1'b1;
          state_d     = S_RESP;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end

      default: begin
        as_n_d  = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  // Reset also drives the bus back to idle straight away, in the middle of an
  // access too. The aborted access gets no response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      as_n_q      <= 1'b1;
      rw_q        <= 1'b1;
      addr_q      <= '0;
      wdata_q     <= '0;
      wd_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register load from the value
      // it had before the edge, whatever order these lines are written in.
      state_q     <= state_d;
      as_n_q      <= as_n_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wd_q        <= wd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign As_       = as_n_q;
  assign RW        = rw_q;
  assign Addr      = addr_q;
  assign WrData    = wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
